dm_lsu: RTL and testbench

Load/store initiator that sits between the CPU datapath and the 1K-word data memory. It accepts byte, halfword and word load/store requests on a valid/ready interface and drives the memory's word address, write data and write enable. Sub-word stores are done as read-modify-write. Loads are extended to 32 bits, and misaligned accesses are flagged.

---
 rtl/dm_lsu.sv | 103 ++++++++++
 tb/tb_dm_lsu.sv | 110 +++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// dm_lsu: byte/half/word load-store initiator with read-modify-write sub-word stores
module dm_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_dmwr,
  input  logic [31:0]       mem_dout
);
  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d, word_q, word_d;
  logic bad;
  logic [31:0] merged, ext;
  logic [7:0] b;
  logic [15:0] h;
  logic unused;
  assign unused = ^req_addr[31:ADDR_W+2];
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    unique case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        uns_d   = req_unsigned;
        size_d  = req_size;
        off_d   = req_addr[1:0];
        idx_d   = req_addr[ADDR_W+1:2];
        wdata_d = req_wdata;
        err_d   = bad;
        state_d = bad ? RSP : (req_we && req_size == 2'b10) ? WR : RD;
      end
      RD: begin
        word_d  = mem_dout;
        state_d = we_q ? WR : RSP;
      end
      WR:      state_d = RSP;
      default: state_d = IDLE;
    endcase
    merged = word_q;
    if (size_q == 2'b10) merged = wdata_q;
    else if (size_q == 2'b01) merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    b   = word_q[{off_q, 3'b000} +: 8];
    h   = off_q[1] ? word_q[31:16] : word_q[15:0];
    ext = size_q == 2'b00 ? {{24{b[7] & ~uns_q}}, b} :
          size_q == 2'b01 ? {{16{h[15] & ~uns_q}}, h} : word_q;
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RSP;
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !we_q && !err_q) ? ext : 32'h0;
    mem_addr  = idx_q;
    mem_din   = state_q == WR ? merged : 32'h0;
    mem_dmwr  = state_q == WR && rst;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: table-driven check of dm_lsu against a behavioural 1K-word memory
module tb_dm_lsu;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, rsp_rdata, mem_din, mem_dout;
  logic rsp_valid, rsp_err, mem_dmwr;
  logic [9:0] mem_addr;
  logic [31:0] mem [1024];
  int tests = 0, fails = 0;
  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr, wdata, rdata;
    logic err; int lat; logic wr; logic [31:0] din; logic [9:0] wa;
  } vec_t;
  vec_t vt [19];
  dm_lsu #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dmwr(mem_dmwr), .mem_dout(mem_dout)
  );
  always #5 clk = ~clk;
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_dmwr) mem[mem_addr] <= mem_din;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  task automatic run(input int i, input vec_t v);
    int lat = 0;
    logic wr = 1'b0, er = 1'b0;
    logic [31:0] din = 32'h0, rd = 32'h0;
    logic [9:0] wa = 10'h0;
    @(negedge clk);
    chk($sformatf("v%0d ready", i), {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (mem_dmwr) begin wr = 1'b1; din = mem_din; wa = mem_addr; end
      if (rsp_valid) begin lat = n; rd = rsp_rdata; er = rsp_err; break; end
    end
    chk($sformatf("v%0d latency", i), lat, v.lat);
    chk($sformatf("v%0d rdata", i), rd, v.rdata);
    chk($sformatf("v%0d err", i), {31'h0, er}, {31'h0, v.err});
    chk($sformatf("v%0d wrote", i), {31'h0, wr}, {31'h0, v.wr});
    if (v.wr) begin
      chk($sformatf("v%0d din", i), din, v.din);
      chk($sformatf("v%0d waddr", i), {22'h0, wa}, {22'h0, v.wa});
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b1, 32'hDEADBEEF, 10'd4};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,   32'h12345655, 32'h0,        1'b0, 3, 1'b1, 32'hDEAD55EF, 10'd4};
    vt[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[4]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h80FF0000, 32'h0,        1'b0, 2, 1'b1, 32'h80FF0000, 10'd4};
    vt[5]  = '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[6]  = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'h00000080, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[7]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'hFFFF80FF, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[8]  = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'h000080FF, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[9]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        32'h00000000, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[10] = '{1'b0, 2'd1, 1'b0, 32'h01,   32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h0,        10'd0};
    vt[11] = '{1'b1, 2'd2, 1'b0, 32'h06,   32'h55,       32'h0,        1'b1, 1, 1'b0, 32'h0,        10'd0};
    vt[12] = '{1'b0, 2'd3, 1'b0, 32'h00,   32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h0,        10'd0};
    vt[13] = '{1'b1, 2'd2, 1'b0, 32'h1010, 32'h11223344, 32'h0,        1'b0, 2, 1'b1, 32'h11223344, 10'd4};
    vt[14] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h11223344, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[15] = '{1'b1, 2'd1, 1'b0, 32'h16,   32'hABCD1234, 32'h0,        1'b0, 3, 1'b1, 32'h12340000, 10'd5};
    vt[16] = '{1'b0, 2'd1, 1'b1, 32'h16,   32'h0,        32'h00001234, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[17] = '{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'h00000044, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    vt[18] = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'h00001122, 1'b0, 2, 1'b0, 32'h0,        10'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'h0, req_ready}, 32'h1);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst dmwr", {31'h0, mem_dmwr}, 32'h0);
    chk("rst mem_addr", {22'h0, mem_addr}, 32'h0);
    chk("rst rdata", rsp_rdata, 32'h0);
    chk("rst din", mem_din, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 19; i++) run(i, vt[i]);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_addr = 32'h10; req_wdata = 32'h0000FFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort rd dmwr", {31'h0, mem_dmwr}, 32'h0);
    @(negedge clk);
    chk("abort wr dmwr", {31'h0, mem_dmwr}, 32'h1);
    rst = 1'b0;
    #1 chk("abort dmwr gated", {31'h0, mem_dmwr}, 32'h0);
    @(negedge clk);
    chk("abort ready", {31'h0, req_ready}, 32'h1);
    chk("abort rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("abort mem word", mem[4], 32'h11223344);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("abort quiet%0d", n), {31'h0, rsp_valid}, 32'h0);
    end
    run(19, vt[14]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
